// File: rtl/univ_shift_reg_pkg.sv
// Shared MODE encoding for the universal shift/count register family.
package univ_shift_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_UP   = 3'd6;
  localparam logic [MODE_W-1:0] MODE_DN   = 3'd7;

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-state for univ_shift_reg_pc; counting modes exist only
// when UNIV_SHIFT_REG_COUNT_EN is defined, otherwise they hold.
module usr_next_val
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin_r,
  input  logic              sin_l,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q_next
);

`ifdef UNIV_SHIFT_REG_COUNT_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives q_next (no latch).
    q_next = q;
    case (mode)
      MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
      MODE_LOAD: q_next = d;
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
`ifdef UNIV_SHIFT_REG_COUNT_EN
      // Carry/borrow dropped: count wraps silently modulo 2^WIDTH.
      MODE_UP:   q_next = q + ONE;
      MODE_DN:   q_next = q - ONE;
`endif
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_pc.sv
// Universal register with async master clear, sync preset/clear, shift,
// rotate, load and (with UNIV_SHIFT_REG_COUNT_EN) up/down count with TC.
module univ_shift_reg_pc
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic              clk,
  input  logic              CLR_L,
  input  logic              PR_L,
  input  logic              SCLR_L,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic              SIN_R,
  input  logic              SIN_L,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  output logic              SOUT_R,
  output logic              SOUT_L,
  output logic              TC
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;

  usr_next_val #(.WIDTH(WIDTH)) u_next (
    .q      (q_r),
    .mode   (MODE),
    .sin_r  (SIN_R),
    .sin_l  (SIN_L),
    .d      (D),
    .q_next (q_next)
  );

  // Preset beats clear, both beat the enable; MODE_HOLD falls out of q_next.
  always_ff @(posedge clk or negedge CLR_L) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (!CLR_L)       q_r <= '0;
    else if (!PR_L)   q_r <= PRESET_VAL;
    else if (!SCLR_L) q_r <= '0;
    else if (EN)      q_r <= q_next;
  end

  assign Q      = q_r;
  assign SOUT_R = q_r[0];
  assign SOUT_L = q_r[WIDTH-1];

`ifdef UNIV_SHIFT_REG_COUNT_EN
  // Flags the edge on which the count will wrap; ignores PR_L/SCLR_L.
  assign TC = EN && (((MODE == MODE_UP) && (&q_r)) ||
                     ((MODE == MODE_DN) && (q_r == '0)));
`else
  assign TC = 1'b0;
`endif

endmodule
